// File: rtl/spi_out_arbiter.sv
// rtl/spi_out_arbiter.sv - packet arbiter sharing the 16-bit SPI output shifter among requesters
// Round robin by default; define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module spi_out_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int PACE    = 16,
  parameter int GAP     = 20
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*16-1:0]    req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [15:0]              spi_data,
  output logic                     spi_write
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PACE_W = $clog2(PACE);
  localparam int GAP_W  = $clog2(GAP + 1);
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(PACE - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   win, win_n, pick, rr_ptr;
  logic               pick_valid;
  logic [LEN_W-1:0]   words_left, words_n, pick_len;
  logic [PACE_W-1:0]  pace_cnt, pace_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [NUM_REQ-1:0] grant_n, ready_n;
  logic [15:0]        data_n, pick_data, win_data;
  logic               write_n, win_req;

`ifdef SPI_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)
      rr_ptr <= '0;
    else if (state == S_IDLE && pick_valid)
      rr_ptr <= (pick == LAST_IDX) ? '0 : pick + 1'b1;
  end
`endif

  // First set request at or above rr_ptr, wrapping past the top index.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_valid && req[idx[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    pick_len  = '0;
    pick_data = '0;
    win_data  = '0;
    win_req   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        pick_len  = req_len[i*LEN_W +: LEN_W];
        pick_data = req_data[i*16 +: 16];
      end
      if (win == IDX_W'(i)) begin
        win_data = req_data[i*16 +: 16];
        win_req  = req[i];
      end
    end
  end

  always_comb begin
    state_n = state;
    win_n   = win;
    words_n = words_left;
    pace_n  = pace_cnt;
    gap_n   = gap_cnt;
    grant_n = grant;
    ready_n = '0;
    write_n = 1'b0;
    data_n  = spi_data;
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          win_n   = pick;
          grant_n = NUM_REQ'(1) << pick;
          ready_n = NUM_REQ'(1) << pick;
          write_n = 1'b1;
          data_n  = pick_data;
          words_n = pick_len;
          pace_n  = PACE_LOAD;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        // A dropped request ends the packet at once; remaining words are abandoned.
        if (!win_req) begin
          grant_n = '0;
          gap_n   = GAP_LOAD;
          state_n = S_GAP;
        end else if (pace_cnt == '0) begin
          if (words_left != '0) begin
            ready_n = grant;
            write_n = 1'b1;
            data_n  = win_data;
            words_n = words_left - 1'b1;
            pace_n  = PACE_LOAD;
          end else begin
            grant_n = '0;
            gap_n   = GAP_LOAD;
            state_n = S_GAP;
          end
        end else begin
          pace_n = pace_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_n = S_IDLE;
        else               gap_n   = gap_cnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= S_IDLE;
      win        <= '0;
      words_left <= '0;
      pace_cnt   <= '0;
      gap_cnt    <= '0;
      grant      <= '0;
      req_ready  <= '0;
      spi_data   <= '0;
      spi_write  <= 1'b0;
    end else begin
      state      <= state_n;
      win        <= win_n;
      words_left <= words_n;
      pace_cnt   <= pace_n;
      gap_cnt    <= gap_n;
      grant      <= grant_n;
      req_ready  <= ready_n;
      spi_data   <= data_n;
      spi_write  <= write_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
